// File: rtl/gobackn_pkg.sv
// Shared Go-Back-N definitions: default widths, sequence/frame types, transmitter
// state encoding and modular sequence distance, reused by transmitter and receiver.
package gobackn_pkg;

    localparam int GBN_SEQ_WIDTH     = 3;
    localparam int GBN_PAYLOAD_WIDTH = 5;

    typedef logic [GBN_SEQ_WIDTH-1:0] seq_t;

    typedef struct packed {
        logic [GBN_PAYLOAD_WIDTH-1:0] payload;
        seq_t                         seq;
    } frame_t;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RETX = 2'd2
    } tx_state_e;

    // Forward distance from a to b, wrapping modulo 2**GBN_SEQ_WIDTH.
    function automatic seq_t seq_dist(input seq_t a, input seq_t b);
        return seq_t'(b - a);
    endfunction

endpackage

// File: rtl/gobackn_transmitter_if.sv
// Producer/link/ack signal bundle of the Go-Back-N transmitter.
// The master modport is the transmitter's view; slave is the environment's view.
interface gobackn_transmitter_if
    import gobackn_pkg::*;
#(
    parameter int SEQ_WIDTH     = GBN_SEQ_WIDTH,
    parameter int PAYLOAD_WIDTH = GBN_PAYLOAD_WIDTH
) ();

    logic [PAYLOAD_WIDTH-1:0]           in_payload;
    logic                               in_valid;
    logic                               in_ready;
    logic [PAYLOAD_WIDTH+SEQ_WIDTH-1:0] tx_data;
    logic                               tx_valid;
    logic                               tx_ready;
    logic [SEQ_WIDTH-1:0]               ack;
    logic                               ack_valid;

    modport master (
        input  in_payload, in_valid, tx_ready, ack, ack_valid,
        output in_ready, tx_data, tx_valid
    );

    modport slave (
        output in_payload, in_valid, tx_ready, ack, ack_valid,
        input  in_ready, tx_data, tx_valid
    );

endinterface

// File: rtl/gobackn_tx_buffer.sv
// Payload store for the Go-Back-N transmitter: written at the next new sequence slot,
// read asynchronously at the slot of the frame about to be placed on the link.
module gobackn_tx_buffer #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 5,
    parameter int AW    = 2
) (
    input  logic             clk,
    input  logic             wr_en,
    input  logic [AW-1:0]    wr_idx,
    input  logic [WIDTH-1:0] wr_data,
    input  logic [AW-1:0]    rd_idx,
    output logic [WIDTH-1:0] rd_data
);

    logic [WIDTH-1:0] mem_q [DEPTH];

    // NOTE: the payload RAM has no reset; whether a slot holds a live frame is
    // decided solely by the sequence pointers, so stale contents are never sent.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_q[wr_idx] <= wr_data;
        end
    end

    assign rd_data = mem_q[rd_idx];

endmodule

// File: rtl/gobackn_transmitter.sv
// Go-Back-N sending end: windowed buffering, cumulative ack handling and timeout retransmission.
// Optional build macro GBN_TX_STATS_EN adds the saturating retx_count output.
module gobackn_transmitter
    import gobackn_pkg::*;
#(
    parameter int N             = 4,
    parameter int SEQ_WIDTH     = gobackn_pkg::GBN_SEQ_WIDTH,
    parameter int PAYLOAD_WIDTH = gobackn_pkg::GBN_PAYLOAD_WIDTH,
    parameter int TIMEOUT       = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    gobackn_transmitter_if.master bus
`ifdef GBN_TX_STATS_EN
    ,
    output logic [15:0]           retx_count
`endif
);

    localparam int CW = $clog2(N + 1);
    localparam int AW = (N > 1) ? $clog2(N) : 1;
    localparam int TW = $clog2(TIMEOUT);

    typedef logic [SEQ_WIDTH-1:0] sq_t;

    localparam sq_t           SEQ_ONE   = sq_t'(1);
    localparam logic [CW-1:0] CNT_ONE   = CW'(1);
    localparam logic [CW-1:0] CNT_MAX   = CW'(N);
    localparam logic [TW-1:0] TIMER_ONE = TW'(1);
    localparam logic [TW-1:0] TIMER_MAX = TW'(TIMEOUT - 1);

    if (N < 1 || N >= (1 << SEQ_WIDTH)) begin : g_bad_window
        $error("gobackn_transmitter: N must satisfy 1 <= N < 2**SEQ_WIDTH");
    end
    if (TIMEOUT < 2) begin : g_bad_timeout
        $error("gobackn_transmitter: TIMEOUT must be at least 2");
    end

    function automatic logic [AW-1:0] slot(input sq_t s);
        return AW'(int'(s) % N);
    endfunction

    sq_t                            base_q, base_d;
    sq_t                            next_seq_q, next_seq_d;
    sq_t                            send_ptr_q, send_ptr_d;
    sq_t                            retx_stop_q, retx_stop_d;
    logic [CW-1:0]                  count_q, count_d;
    logic [TW-1:0]                  timer_q, timer_d;
    tx_state_e                      state_q, state_d;
    logic                           tx_valid_q, tx_valid_d;
    logic                           in_ready_q, in_ready_d;
    logic [PAYLOAD_WIDTH+SEQ_WIDTH-1:0] tx_data_q, tx_data_d;

    logic                     accept, tx_fire, ack_ok, timeout;
    sq_t                      sp_adv, ack_limit, ack_dist, sent_dist, ack_span, sp_dist;
    logic [PAYLOAD_WIDTH-1:0] rd_payload, tx_payload;

    always_comb begin
        // NOTE: every signal gets a default before any branch so no path infers a latch.
        accept    = bus.in_valid && in_ready_q;
        tx_fire   = tx_valid_q && bus.tx_ready;
        sp_adv    = send_ptr_q + (tx_fire ? SEQ_ONE : '0);
        // While retransmitting, frames up to the pre-timeout send point count as sent.
        ack_limit = (state_q == ST_RETX) ? retx_stop_q : send_ptr_q;
        ack_dist  = bus.ack - base_q;
        sent_dist = ack_limit - base_q;
        ack_span  = ack_dist + SEQ_ONE;
        sp_dist   = sp_adv - base_q;
        ack_ok    = bus.ack_valid && (ack_dist < sent_dist);
        timeout   = (state_q != ST_RETX) && (base_q != send_ptr_q) &&
                    (timer_q == TIMER_MAX) && !ack_ok;

        base_d      = ack_ok ? (bus.ack + SEQ_ONE) : base_q;
        next_seq_d  = next_seq_q + (accept ? SEQ_ONE : '0);
        count_d     = count_q + (accept ? CNT_ONE : '0) - (ack_ok ? CW'(ack_span) : '0);
        send_ptr_d  = sp_adv;
        retx_stop_d = retx_stop_q;
        if (timeout) begin
            send_ptr_d  = base_q;
            retx_stop_d = sp_adv;
        end else if (ack_ok && (sp_dist < ack_span)) begin
            send_ptr_d = base_d;
        end

        if (ack_ok || timeout || state_q == ST_RETX || base_q == send_ptr_q) begin
            timer_d = '0;
        end else begin
            timer_d = timer_q + TIMER_ONE;
        end

        state_d = state_q;
        unique case (state_q)
            ST_IDLE: if (tx_fire) state_d = ST_WAIT;
            ST_WAIT: begin
                if (timeout)                   state_d = ST_RETX;
                else if (base_d == next_seq_d) state_d = ST_IDLE;
            end
            ST_RETX: if (send_ptr_d == retx_stop_q) state_d = ST_WAIT;
            default: state_d = ST_IDLE;
        endcase

        in_ready_d = (count_d < CNT_MAX) && (state_d != ST_RETX);
        tx_valid_d = (send_ptr_d != next_seq_d);
    end

    // A payload accepted this cycle may be the very frame to present next.
    always_comb begin
        tx_payload = (accept && send_ptr_d == next_seq_q) ? bus.in_payload : rd_payload;
        tx_data_d  = {tx_payload, send_ptr_d};
    end

    gobackn_tx_buffer #(
        .DEPTH (N),
        .WIDTH (PAYLOAD_WIDTH),
        .AW    (AW)
    ) u_buffer (
        .clk     (clk),
        .wr_en   (accept),
        .wr_idx  (slot(next_seq_q)),
        .wr_data (bus.in_payload),
        .rd_idx  (slot(send_ptr_d)),
        .rd_data (rd_payload)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            base_q      <= '0;
            next_seq_q  <= '0;
            send_ptr_q  <= '0;
            retx_stop_q <= '0;
            count_q     <= '0;
            timer_q     <= '0;
            state_q     <= ST_IDLE;
            tx_valid_q  <= 1'b0;
            in_ready_q  <= 1'b1;
            tx_data_q   <= '0;
        end else begin
            base_q      <= base_d;
            next_seq_q  <= next_seq_d;
            send_ptr_q  <= send_ptr_d;
            retx_stop_q <= retx_stop_d;
            count_q     <= count_d;
            timer_q     <= timer_d;
            state_q     <= state_d;
            tx_valid_q  <= tx_valid_d;
            in_ready_q  <= in_ready_d;
            tx_data_q   <= tx_data_d;
        end
    end

    assign bus.in_ready = in_ready_q;
    assign bus.tx_valid = tx_valid_q;
    assign bus.tx_data  = tx_data_q;

`ifdef GBN_TX_STATS_EN
    logic [15:0] retx_count_q, retx_count_d;

    always_comb begin
        retx_count_d = retx_count_q;
        if (timeout && retx_count_q != 16'hFFFF) begin
            retx_count_d = retx_count_q + 16'd1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) retx_count_q <= '0;
        else        retx_count_q <= retx_count_d;
    end

    assign retx_count = retx_count_q;
`endif

endmodule

// File: tb/tb_gobackn_transmitter.sv
// Scoreboard bench for gobackn_transmitter: expected frames are queued as payloads are
// issued and a negedge monitor compares every frame the link takes.
module tb_gobackn_transmitter;
    import gobackn_pkg::*;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    gobackn_transmitter_if bus ();

`ifdef GBN_TX_STATS_EN
    logic [15:0] retx_count;
`endif

    gobackn_transmitter #(
        .N             (4),
        .SEQ_WIDTH     (3),
        .PAYLOAD_WIDTH (5),
        .TIMEOUT       (16)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
`ifdef GBN_TX_STATS_EN
        ,
        .retx_count (retx_count)
`endif
    );

    int         checks   = 0;
    int         failures = 0;
    logic [7:0] exp_q[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=0x%0h required=0x%0h at %0t", name, act, req, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [4:0] p, input logic [7:0] frame);
        int n = 0;
        bus.in_payload = p;
        bus.in_valid   = 1'b1;
        while (!bus.in_ready && n < 100) begin
            tick();
            n++;
        end
        check("send_in_ready", 32'(bus.in_ready), 32'd1);
        tick();
        bus.in_valid = 1'b0;
        exp_q.push_back(frame);
    endtask

    task automatic do_ack(input logic [2:0] a);
        bus.ack       = a;
        bus.ack_valid = 1'b1;
        tick();
        bus.ack_valid = 1'b0;
    endtask

    task automatic drain(input string name);
        int n = 0;
        while (exp_q.size() != 0 && n < 200) begin
            tick();
            n++;
        end
        check(name, 32'(exp_q.size()), 32'd0);
    endtask

    task automatic apply_reset();
        reset          = 1'b0;
        bus.in_valid   = 1'b0;
        bus.in_payload = '0;
        bus.tx_ready   = 1'b1;
        bus.ack        = '0;
        bus.ack_valid  = 1'b0;
        repeat (3) tick();
        check("rst_tx_valid", 32'(bus.tx_valid), 32'd0);
        check("rst_in_ready", 32'(bus.in_ready), 32'd1);
        check("rst_tx_data",  32'(bus.tx_data),  32'h00);
        check("rst_count",    32'(dut.count_q),  32'd0);
        reset = 1'b1;
        tick();
    endtask

    // Scoreboard monitor: a frame is taken at the next rising edge.
    always @(negedge clk) begin
        if (reset === 1'b1 && bus.tx_valid === 1'b1 && bus.tx_ready === 1'b1) begin
            if (exp_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL frame_unexpected actual=0x%0h required=none at %0t", bus.tx_data, $time);
            end else begin
                check("frame", 32'(bus.tx_data), 32'(exp_q.pop_front()));
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog actual=running required=finished");
        $fatal(1);
    end

    initial begin
        frame_t     f;
        logic [4:0] p;
        logic [2:0] s;
        int         n;

        // Basic stamping of three payloads.
        apply_reset();
        send(5'h01, 8'h08);
        send(5'h02, 8'h11);
        send(5'h03, 8'h1A);
        drain("drain_basic");
        do_ack(3'd2);
        check("basic_count", 32'(dut.count_q), 32'd0);

        // Window fill and partial cumulative ack.
        apply_reset();
        send(5'h04, 8'h20);
        send(5'h05, 8'h29);
        send(5'h06, 8'h32);
        send(5'h07, 8'h3B);
        check("full_in_ready", 32'(bus.in_ready), 32'd0);
        drain("drain_full");
        do_ack(3'd1);
        check("ack1_count",    32'(dut.count_q), 32'd2);
        check("ack1_in_ready", 32'(bus.in_ready), 32'd1);
        do_ack(3'd3);
        check("ack3_count", 32'(dut.count_q), 32'd0);

        // Timeout: all four outstanding frames go out again in order.
        apply_reset();
        send(5'h0A, 8'h50);
        send(5'h0B, 8'h59);
        send(5'h0C, 8'h62);
        send(5'h0D, 8'h6B);
        exp_q.push_back(8'h50);
        exp_q.push_back(8'h59);
        exp_q.push_back(8'h62);
        exp_q.push_back(8'h6B);
        drain("drain_retx");
`ifdef GBN_TX_STATS_EN
        check("retx_count", 32'(retx_count), 32'd1);
`endif
        do_ack(3'd3);
        check("retx_done_count", 32'(dut.count_q), 32'd0);

        // Sequence wrap 7 -> 0 with an ack after each frame.
        apply_reset();
        for (int i = 0; i < 10; i++) begin
            p = 5'(i + 16);
            s = 3'(i);
            f.payload = p;
            f.seq     = s;
            send(p, 8'(f));
            drain("drain_wrap");
            do_ack(s);
            if (i == 7) check("wrap_base_ack7", 32'(dut.base_q), 32'd0);
            if (i == 8) check("wrap_base_ack0", 32'(dut.base_q), 32'd1);
        end
        check("wrap_base_final",  32'(dut.base_q),  32'd2);
        check("wrap_count_final", 32'(dut.count_q), 32'd0);

        // Stale ack ignored; ack coincident with timeout suppresses retransmission.
        apply_reset();
        send(5'h01, 8'h08);
        send(5'h02, 8'h11);
        send(5'h03, 8'h1A);
        drain("drain_stale");
        do_ack(3'd0);
        do_ack(3'd5);
        check("stale_base",  32'(dut.base_q),  32'd1);
        check("stale_count", 32'(dut.count_q), 32'd2);
        n = 0;
        while (dut.timer_q != 4'd15 && n < 100) begin
            tick();
            n++;
        end
        check("timer_reached", 32'(dut.timer_q), 32'd15);
        do_ack(3'd1);
        check("coinc_state",    32'(dut.state_q),    32'(ST_WAIT));
        check("coinc_send_ptr", 32'(dut.send_ptr_q), 32'd3);
        check("coinc_base",     32'(dut.base_q),     32'd2);
        repeat (4) tick();
        do_ack(3'd2);
        check("coinc_count", 32'(dut.count_q), 32'd0);

        // Reset asserted in the middle of a retransmission.
        apply_reset();
        send(5'h11, 8'h88);
        send(5'h12, 8'h91);
        send(5'h13, 8'h9A);
        send(5'h14, 8'hA3);
        drain("drain_pre_reset");
        bus.tx_ready = 1'b0;
        n = 0;
        while (dut.state_q != ST_RETX && n < 100) begin
            tick();
            n++;
        end
        check("retx_state",    32'(dut.state_q),   32'(ST_RETX));
        check("retx_in_ready", 32'(bus.in_ready),  32'd0);
        check("retx_tx_valid", 32'(bus.tx_valid),  32'd1);
        check("retx_tx_data",  32'(bus.tx_data),   32'h88);
        reset = 1'b0;
        #1;
        check("midrst_tx_valid", 32'(bus.tx_valid), 32'd0);
        check("midrst_tx_data",  32'(bus.tx_data),  32'h00);
        check("midrst_in_ready", 32'(bus.in_ready), 32'd1);
        repeat (2) tick();
        reset        = 1'b1;
        bus.tx_ready = 1'b1;
        tick();
        send(5'h15, 8'hA8);
        drain("drain_post_reset");
        do_ack(3'd0);
        check("post_reset_count", 32'(dut.count_q), 32'd0);

        repeat (3) tick();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/gobackn_transmitter.md
Name: gobackn_transmitter

Overview:
Sending end of the Go-Back-N link. Accepts payloads from an upstream producer, stamps each with a SEQ_WIDTH sequence number and emits 8-bit frames (seq in [2:0], payload in [7:3]) towards the receiver. Holds up to N unacknowledged frames in a circular buffer. Consumes cumulative acks from the receiver. On timeout, retransmits every outstanding frame, starting from the oldest unacked one.

Parameters:
N, 4, window size (max outstanding frames); elaboration error unless 1 <= N < 2**SEQ_WIDTH
SEQ_WIDTH, 3, sequence number width; frame bits [SEQ_WIDTH-1:0]
PAYLOAD_WIDTH, 5, payload bits; frame width = PAYLOAD_WIDTH+SEQ_WIDTH = 8
TIMEOUT, 16, cycles without base advance before go-back retransmission; >= 2

Ports:
clk  in  1  clock, all state on rising edge
reset  in  1  asynchronous, active-low reset (0 = reset asserted)
in_payload  in  PAYLOAD_WIDTH  payload from producer
in_valid  in  1  in_payload valid
in_ready  out  1  buffer can accept; transfer when in_valid & in_ready
tx_data  out  8  frame {payload, seq}
tx_valid  out  1  tx_data valid; frame taken when tx_valid & tx_ready
tx_ready  in  1  link can take a frame this cycle
ack  in  SEQ_WIDTH  cumulative ack: highest in-order seq received
ack_valid  in  1  ack valid this cycle

Behaviour:
- Registers: base (oldest unacked seq), next_seq (next new seq), send_ptr (next seq to put on link), count (0..N outstanding+buffered), timer.
- Reset (async, reset=0): base=next_seq=send_ptr=0, count=0, timer=0, state IDLE, tx_valid=0, in_ready=1, tx_data=0. Reset mid-retransmission discards all buffered frames.
- in_ready = (count < N) && state != RETX. On accept: buffer[next_seq mod N] <= in_payload, next_seq+1 mod 2**SEQ_WIDTH, count+1.
- tx_valid is registered and reflects send_ptr != next_seq; tx_data = {buffer[send_ptr mod N], send_ptr}. On tx_valid & tx_ready, send_ptr advances. Latency: accept at cycle t -> tx_valid no earlier than t+1.
- Ack: valid iff d = (ack - base) mod 2**SEQ_WIDTH satisfies d < (send_ptr - base) mod 2**SEQ_WIDTH (covers only frames already sent). Valid ack -> base <= ack+1, count <= count-(d+1), timer cleared. Invalid/duplicate/stale ack ignored, no state change.
- Timer: counts while base != send_ptr and state != RETX, cleared on base advance or when nothing is outstanding. When timer reaches TIMEOUT-1: send_ptr <= base, state -> RETX, timer cleared.
- States: IDLE (nothing sent and unacked) -> WAIT (frames outstanding) on first transmit; WAIT -> IDLE when base == next_seq; WAIT -> RETX on timeout; RETX -> WAIT when send_ptr catches up to the pre-timeout send point.
- Simultaneous events: ack and accept in one cycle both apply, count = count + 1 - (d+1). Ack and timeout in one cycle: ack wins, timer cleared, no retransmission. Ack during RETX that moves base past send_ptr: send_ptr <= new base.
- All seq arithmetic is mod 2**SEQ_WIDTH, with wrap-around 7 -> 0.

Optional Feature:
GBN_TX_STATS_EN: when defined, adds output retx_count [15:0], which counts timeout events and saturates at 16'hFFFF. Reset clears it to 0. When not defined, the port and counter do not exist and behaviour is otherwise identical.

Decomposition:
- Shared package gobackn_pkg holds: SEQ_WIDTH/PAYLOAD_WIDTH defaults, the seq_t typedef, a frame_t packed struct {payload, seq}, the tx state enum, and a seq_dist(a,b) mod-distance function. The receiver is to reuse these.
- One natural sub-module: gobackn_tx_buffer (N-entry payload RAM, write at next_seq, read at send_ptr).

Test Plan:
- Reset, then 3 payloads 5'h01,5'h02,5'h03 with tx_ready=1 -> tx_data 8'h08,8'h11,8'h1A (seq 0,1,2) on consecutive cycles.
- Send 4 frames without acks -> in_ready=0 after 4th accept; ack=1 valid -> count=2, in_ready=1 next cycle.
- Send seq 0..3, no acks for 16 cycles -> tx_valid resends seq 0,1,2,3 in order; with GBN_TX_STATS_EN, retx_count=1.
- Push 10 frames with an ack after each -> seq wraps 7->0; ack=7 then ack=0 are both accepted, base ends at 2.
- Stale ack=5 while base=1 and 2 frames outstanding -> ignored, no change to base or count; ack coincident with timeout -> no retransmission.
- Pull reset to 0 mid-RETX -> tx_valid=0 immediately; after release, first frame carries seq 0.
